serial_subtractor_8bit: RTL and testbench
=========================================

# serial_subtractor_8bit

Bit-serial unsigned subtractor with borrow-in/borrow-out, the counterpart to the team's 8-bit ripple-carry adder. It computes a − b − bin one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flop. It trades latency for area in datapaths that need a subtract but cannot afford a parallel borrow chain. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend, unsigned.
- b  in  WIDTH  subtrahend, unsigned.
- bin  in  1  borrow in.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  out  1  borrow out: 1 if and only if a < b + bin (unsigned).

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a and b into shift registers, load the borrow flop with bin, clear the bit counter, go to BUSY.
- BUSY:
  - Each cycle, the cell takes a_sh[0], b_sh[0] and the borrow flop.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - d shifts into diff_sh at the MSB end. a_sh and b_sh shift right. The borrow flop takes br_next.
  - The counter increments each cycle. When the counter reaches WIDTH−1, the same edge moves to DONE.
- DONE:
  - diff = diff_sh and bout = the borrow flop; both are registered.
  - out_valid = 1.
  - On out_ready, go to IDLE.
- in_valid outside IDLE is ignored and no operands are captured. Operands need not be held after acceptance.
- diff and bout keep their last values after the handshake, until the next result overwrites them.
- Reset values: out_valid 0, diff 0, bout 0, in_ready 1 (state IDLE), counter 0, shift registers 0.
- Reset mid-operation, in BUSY or DONE:
  - The operation is aborted and no result is presented.
  - The block is in IDLE on the cycle after the reset edge.
- Counter width is $clog2(WIDTH). All arithmetic is unsigned modulo 2^WIDTH.

## Timing
- Operands are accepted at edge T.
- BUSY occupies the cycles after edges T … T+WIDTH−1. For WIDTH=8 that is 8 cycles.
- out_valid rises after edge T+WIDTH.
- If out_ready is already high, the result handshake completes at edge T+WIDTH+1 and in_ready is high after that edge.
- Minimum initiation interval is WIDTH+2 cycles. There is no overlap between operations.
- out_valid, diff and bout are stable while out_valid && !out_ready.
- in_ready is a combinational decode of state only. It never depends on in_valid or out_ready.

## Structure
- Shared package (sub_pkg):
  - state enum {IDLE, BUSY, DONE}.
  - Default width constant SUB_WIDTH = 8.
- Sub-module full_subtractor: 1-bit cell with ports a, b, bin, diff, bout. It is purely combinational and is instantiated once.
- The top level holds the FSM, counter, shift registers and borrow flop.

## Test plan
- a=8'h5A, b=8'h3C, bin=0 -> diff=8'h1E, bout=0. out_valid rises exactly 8 cycles after acceptance.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Also a=8'h00, b=8'hFF, bin=1 -> diff=8'h00, bout=1.
- a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1. Also a=8'hFF, b=8'h00, bin=0 -> diff=8'hFF, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, diff and bout stay unchanged, in_ready stays 0. Raising out_ready gives one handshake, then IDLE.
- Pulse in_valid with new operands during BUSY -> ignored; the result reflects the original operands only.
- Assert rst on the 3rd BUSY cycle -> out_valid never rises, in_ready=1 on the next cycle. A fresh 8'h10 − 8'h01 then yields 8'h0F, bout=0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

   // Default operand and result width
   localparam int unsigned SUB_WIDTH = 8;

   // Control states of the serial subtractor
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   // Difference bit and borrow out of a single bit position
   always_comb begin
      diff = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule : full_subtractor

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first,
// one bit per clock, valid/ready handshakes on operands and result.
module serial_subtractor_8bit
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
   logic [WIDTH-1:0]   diff_sh_q,   diff_sh_d;
   logic               br_q,        br_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   diff_q,      diff_d;
   logic               bout_q,      bout_d;

   logic               cell_diff;
   logic               cell_bout;
   logic [WIDTH-1:0]   diff_sh_next;

   // Single shared subtractor cell fed by the operand LSBs and the borrow flop
   full_subtractor u_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // Result bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts
   always_comb begin
      diff_sh_next = {cell_diff, diff_sh_q[WIDTH-1:1]};
   end

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      diff_sh_d   = diff_sh_q;
      br_d        = br_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      bout_d      = bout_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end

         BUSY: begin
            diff_sh_d = diff_sh_next;
            a_sh_d    = a_sh_q >> 1;
            b_sh_d    = b_sh_q >> 1;
            br_d      = cell_bout;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // Last bit: publish the completed difference and final borrow
               state_d     = DONE;
               out_valid_d = 1'b1;
               diff_d      = diff_sh_next;
               bout_d      = cell_bout;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end

         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         diff_sh_q   <= '0;
         br_q        <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         diff_sh_q   <= diff_sh_d;
         br_q        <= br_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
      end
   end

   // Operand acceptance is a pure decode of the state register
   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule : serial_subtractor_8bit

// File: tb/tb_serial_subtractor_8bit.sv
// Scoreboard bench for the bit-serial subtractor.
module tb_serial_subtractor_8bit;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;

   int tests = 0;
   int fails = 0;

   // expected {bout, diff}
   logic [W:0] exp_q[$];

   serial_subtractor_8bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
   );

   always #5 clk = ~clk;

   // Reference: plain signed arithmetic on the operand values
   function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rbin);
      int r;
      logic [W-1:0] d;
      r = int'(ra) - int'(rb) - int'(rbin);
      d = W'(r & ((1 << W) - 1));
      return {(r < 0), d};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: pops expected result on every result handshake
   initial begin
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("diff", 32'(diff), 32'(e[W-1:0]));
               check("bout", 32'(bout), 32'(e[W]));
            end
         end
      end
   end

   // ready_mode: 0 = out_ready high, 1 = random, 2 = held low 5 cycles in DONE
   // inject_k / rst_k: BUSY cycle index (after edge T+k) for in_valid pulse / reset; -1 none
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_i, input logic tbin,
                         input int ready_mode, input int inject_k, input int rst_k);
      logic [W:0] e;
      bit seen;
      bit ready_ok;
      int lat;
      int hs;
      e = ref_sub(ta, tb_i, tbin);
      ready_ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready === 1'b1) begin
            ready_ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ready_ok) check("in_ready_wait", 32'(in_ready), 32'd1);

      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
      a = ta; b = tb_i; bin = tbin; in_valid = 1'b1;
      if (rst_k < 0) exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      check("in_ready_busy", 32'(in_ready), 32'd0);

      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= int'(W) + 4; k++) begin
         in_valid = ((k - 1) == inject_k);
         if ((k - 1) == inject_k) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         end
         rst = ((k - 1) == rst_k);
         if (ready_mode == 1) out_ready = 1'($urandom % 2);
         @(posedge clk); #1;
         in_valid = 1'b0;
         rst = 1'b0;
         if (rst_k >= 0 && k == rst_k + 1) begin
            check("in_ready_after_rst", 32'(in_ready), 32'd1);
            check("out_valid_after_rst", 32'(out_valid), 32'd0);
         end
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            lat = k;
            break;
         end
      end

      if (rst_k >= 0) begin
         check("abort_no_result", 32'(seen), 32'd0);
         return;
      end
      check("latency", 32'(lat), 32'(W));

      if (ready_mode == 2) begin
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff", 32'(diff), 32'(e[W-1:0]));
            check("bp_bout", 32'(bout), 32'(e[W]));
            check("bp_in_ready", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end

      hs = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b1) break;
         if (ready_mode == 1) out_ready = (i > 20) ? 1'b1 : 1'($urandom % 2);
         @(posedge clk); #1;
         hs++;
      end
      if (ready_mode != 1) check("handshake_cycles", 32'(hs), 32'd1);
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_after_hs", 32'(in_ready), 32'd1);
      check("diff_held", 32'(diff), 32'(e[W-1:0]));
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed cases
      run_op(8'h5A, 8'h3C, 1'b0, 0, -1, -1);
      run_op(8'h00, 8'h01, 1'b0, 0, -1, -1);
      run_op(8'h00, 8'hFF, 1'b1, 0, -1, -1);
      run_op(8'hFF, 8'hFF, 1'b1, 0, -1, -1);
      run_op(8'hFF, 8'h00, 1'b0, 0, -1, -1);
      // Backpressure in DONE
      run_op(8'hA7, 8'h3B, 1'b1, 2, -1, -1);
      // in_valid pulse during BUSY is ignored
      run_op(8'h81, 8'h7E, 1'b0, 0, 3, -1);
      // Reset on the 3rd BUSY cycle aborts, then a fresh operation
      run_op(8'h55, 8'h22, 1'b0, 0, -1, 2);
      for (int i = 0; i < int'(W) + 4; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) check("abort_quiet", 32'(out_valid), 32'd0);
      end
      check("abort_idle", 32'(in_ready), 32'd1);
      run_op(8'h10, 8'h01, 1'b0, 0, -1, -1);

      // Randomized operations with random backpressure
      for (int n = 0; n < 40; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), (n % 3 == 0) ? 0 : 1,
                (n % 5 == 0) ? int'($urandom_range(0, W - 1)) : -1, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule : tb_serial_subtractor_8bit
